dmem_arbiter: RTL

Two-requester arbiter that shares the single-port data memory between the CPU memory stage and the UART program/data loader. Each requester posts a single-cycle request pulse. The block captures the request, grants the memory port round-robin, or to the loader with strict priority while loader mode is active. It drives the memory port and returns registered read data with an acknowledge pulse. It sits between the CPU/MemOrIO path, the UART loader and the data memory, on the CPU clock.

---
 rtl/dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage and the UART
// loader: per-requester capture, round-robin or loader-priority grant, registered responses.
module dmem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              ld_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_busy,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
    output logic              ld_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        ovr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LD  = 1'b1;

    state_t state_r, state_s;

    logic              cpu_pend_r, cpu_we_r;
    logic [ADDR_W-1:0] cpu_waddr_r;
    logic [DATA_W-1:0] cpu_wdata_r;
    logic              ld_pend_r, ld_we_r;
    logic [ADDR_W-1:0] ld_waddr_r;
    logic [DATA_W-1:0] ld_wdata_r;

    logic              gnt_r, last_gnt_r, iss_we_r, mem_we_r;
    logic [ADDR_W-1:0] iss_addr_r;
    logic [DATA_W-1:0] iss_wdata_r;
    logic [DATA_W-1:0] cpu_rdata_r, ld_rdata_r;
    logic              cpu_ack_r, ld_ack_r, cpu_busy_r, ld_busy_r;
    logic [1:0]        ovr_r;

    logic              any_pend_s, gnt_ld_s, grant_s, resp_s;
    logic              cpu_clr_s, ld_clr_s, cpu_take_s, ld_take_s;
    logic              cpu_pend_s, ld_pend_s, cpu_ack_s, ld_ack_s;
    logic              gnt_s, cpu_busy_s, ld_busy_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [1:0]        ovr_s;
    logic              addr_unused_s;

    // Only the word-address slice of each byte address is used.
    assign addr_unused_s = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                             ld_addr[31:ADDR_W+2], ld_addr[1:0]};

    // Arbitration: loader wins under ld_mode, otherwise alternate when contended
    always_comb begin
        any_pend_s = cpu_pend_r | ld_pend_r;
        gnt_ld_s   = GNT_CPU;
        if (ld_pend_r && (ld_mode || !cpu_pend_r || (last_gnt_r == GNT_CPU))) begin
            gnt_ld_s = GNT_LD;
        end else begin
            gnt_ld_s = GNT_CPU;
        end
        sel_we_s    = cpu_we_r;
        sel_addr_s  = cpu_waddr_r;
        sel_wdata_s = cpu_wdata_r;
        if (gnt_ld_s == GNT_LD) begin
            sel_we_s    = ld_we_r;
            sel_addr_s  = ld_waddr_r;
            sel_wdata_s = ld_wdata_r;
        end else begin
            sel_we_s    = cpu_we_r;
            sel_addr_s  = cpu_waddr_r;
            sel_wdata_s = cpu_wdata_r;
        end
    end

    // Next-state logic for the IDLE/ISSUE/RESP access sequencer
    always_comb begin
        state_s = state_r;
        grant_s = 1'b0;
        resp_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_pend_s) begin
                    grant_s = 1'b1;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                resp_s = 1'b1;
                if (any_pend_s) begin
                    grant_s = 1'b1;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Capture, overrun, acknowledge and busy next values
    always_comb begin
        cpu_clr_s  = grant_s && (gnt_ld_s == GNT_CPU);
        ld_clr_s   = grant_s && (gnt_ld_s == GNT_LD);
        // A request landing on the edge that grants the old one is accepted.
        cpu_take_s = cpu_req && (!cpu_pend_r || cpu_clr_s);
        ld_take_s  = ld_req && (!ld_pend_r || ld_clr_s);
        if (cpu_take_s) begin
            cpu_pend_s = 1'b1;
        end else if (cpu_clr_s) begin
            cpu_pend_s = 1'b0;
        end else begin
            cpu_pend_s = cpu_pend_r;
        end
        if (ld_take_s) begin
            ld_pend_s = 1'b1;
        end else if (ld_clr_s) begin
            ld_pend_s = 1'b0;
        end else begin
            ld_pend_s = ld_pend_r;
        end
        ovr_s = ovr_r | {ld_req && ld_pend_r && !ld_clr_s,
                         cpu_req && cpu_pend_r && !cpu_clr_s};
        if (grant_s) begin
            gnt_s = gnt_ld_s;
        end else begin
            gnt_s = gnt_r;
        end
        cpu_ack_s  = resp_s && (gnt_r == GNT_CPU);
        ld_ack_s   = resp_s && (gnt_r == GNT_LD);
        cpu_busy_s = cpu_pend_s || ((state_s != ST_IDLE) && (gnt_s == GNT_CPU)) || cpu_ack_s;
        ld_busy_s  = ld_pend_s || ((state_s != ST_IDLE) && (gnt_s == GNT_LD)) || ld_ack_s;
    end

    // Requester capture registers and sticky overrun flags
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cpu_pend_r  <= 1'b0;
            cpu_we_r    <= 1'b0;
            cpu_waddr_r <= '0;
            cpu_wdata_r <= '0;
            ld_pend_r   <= 1'b0;
            ld_we_r     <= 1'b0;
            ld_waddr_r  <= '0;
            ld_wdata_r  <= '0;
            ovr_r       <= 2'b00;
        end else begin
            cpu_pend_r <= cpu_pend_s;
            ld_pend_r  <= ld_pend_s;
            ovr_r      <= ovr_s;
            if (cpu_take_s) begin
                cpu_we_r    <= cpu_we;
                cpu_waddr_r <= cpu_addr[ADDR_W+1:2];
                cpu_wdata_r <= cpu_wdata;
            end
            if (ld_take_s) begin
                ld_we_r    <= ld_we;
                ld_waddr_r <= ld_addr[ADDR_W+1:2];
                ld_wdata_r <= ld_wdata;
            end
        end
    end

    // Sequencer state, grant history, memory port and response registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gnt_r       <= GNT_CPU;
            last_gnt_r  <= GNT_LD;
            iss_we_r    <= 1'b0;
            iss_addr_r  <= '0;
            iss_wdata_r <= '0;
            mem_we_r    <= 1'b0;
            cpu_rdata_r <= '0;
            ld_rdata_r  <= '0;
            cpu_ack_r   <= 1'b0;
            ld_ack_r    <= 1'b0;
            cpu_busy_r  <= 1'b0;
            ld_busy_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            cpu_ack_r  <= cpu_ack_s;
            ld_ack_r   <= ld_ack_s;
            cpu_busy_r <= cpu_busy_s;
            ld_busy_r  <= ld_busy_s;
            // mem_we is high only for the ISSUE cycle that follows a grant.
            mem_we_r   <= grant_s && sel_we_s;
            if (grant_s) begin
                last_gnt_r  <= gnt_ld_s;
                iss_we_r    <= sel_we_s;
                iss_addr_r  <= sel_addr_s;
                iss_wdata_r <= sel_wdata_s;
            end
            if (resp_s && !iss_we_r) begin
                if (gnt_r == GNT_LD) begin
                    ld_rdata_r <= mem_rdata;
                end else begin
                    cpu_rdata_r <= mem_rdata;
                end
            end
        end
    end

    assign mem_we    = mem_we_r;
    assign mem_addr  = iss_addr_r;
    assign mem_wdata = iss_wdata_r;
    assign cpu_rdata = cpu_rdata_r;
    assign ld_rdata  = ld_rdata_r;
    assign cpu_ack   = cpu_ack_r;
    assign ld_ack    = ld_ack_r;
    assign cpu_busy  = cpu_busy_r;
    assign ld_busy   = ld_busy_r;
    assign ovr       = ovr_r;

endmodule
